// File: rtl/wb_reg_responder.sv
// ---------------------------------------------------------------------------
// wb_reg_responder
// WISHBONE slave exposing a small register file:
//   0x0 ID (RO), 0x1 VERSION (RO), 0x2 SCRATCH (RW), 0x3 CONTROL (RW),
//   0x4 COUNTER (RO, free-running), 0x5 ERRCNT (RO, write-to-clear).
// Each request gets one ack_o/err_o pulse LATENCY+1 cycles after it is
// sampled.
//
// Ports:
//   clk_i      - clock, all state on rising edge
//   rst_i      - asynchronous active-low reset
//   cyc_i      - WISHBONE cycle
//   stb_i      - WISHBONE strobe
//   we_i       - WISHBONE write enable
//   adr_i      - byte address; word offset is adr_i[15:2]
//   dat_i      - write data
//   sel_i      - byte selects
//   ack_o      - normal termination
//   err_o      - error termination (unmapped offset)
//   rty_o      - retry termination, never used (tied 0)
//   dat_o      - read data, held until the next response
//   control_o  - CONTROL[7:0]
//   pulse_o    - one-cycle strobe after a CONTROL write with bit 31 set
// ---------------------------------------------------------------------------
module wb_reg_responder #(
    parameter logic [31:0] IDENT   = 32'h52445742,
    parameter logic [31:0] VERSION = 32'h00010000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [15:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic [31:0] dat_o,
    output logic [7:0]  control_o,
    output logic        pulse_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [2:0] WAIT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

    state_t      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] scratch_q;
    logic [7:0]  control_q;
    logic [31:0] counter_q;
    logic [15:0] errcnt_q;
    logic [31:0] dat_q;
    logic        resp_err_q;
    logic        pulse_q;

    logic        req;
    logic [13:0] offset;
    logic        addr_err;
    logic        enter_resp;
    logic [31:0] rd_data;

    assign req      = cyc_i & stb_i;
    assign offset   = adr_i[15:2];
    assign addr_err = (offset > 14'd5);

    // The edge that moves the FSM into RESP is the one that commits writes
    // and captures read data, so it is computed once and shared.
    assign enter_resp = ((state_q == IDLE) && req && (LATENCY == 0)) ||
                        ((state_q == WAIT) && req && (wait_q == 3'd0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Strobes are only looked at in IDLE and WAIT; RESP always falls back
    // to IDLE so a held strobe starts a fresh transaction.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    wait_d  = 3'd0;
                end else if (wait_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_data = 32'd0;
        case (offset)
            14'd0:   rd_data = IDENT;
            14'd1:   rd_data = VERSION;
            14'd2:   rd_data = scratch_q;
            14'd3:   rd_data = {24'd0, control_q};
            14'd4:   rd_data = counter_q;
            14'd5:   rd_data = {16'd0, errcnt_q};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            counter_q <= 32'd0;
        end else begin
            counter_q <= counter_q + 32'd1;
        end
    end

    // Only byte 0 of CONTROL is storage; the upper bytes always read 0,
    // so bit 31 of a write acts purely as the pulse command.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            scratch_q  <= 32'd0;
            control_q  <= 8'd0;
            errcnt_q   <= 16'd0;
            dat_q      <= 32'd0;
            resp_err_q <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (enter_resp) begin
                resp_err_q <= addr_err;
                dat_q      <= rd_data;
                if (addr_err) begin
                    if (errcnt_q != 16'hFFFF) begin
                        errcnt_q <= errcnt_q + 16'd1;
                    end
                end else if (we_i) begin
                    if (offset == 14'd2) begin
                        for (int b = 0; b < 4; b++) begin
                            if (sel_i[b]) begin
                                scratch_q[8*b +: 8] <= dat_i[8*b +: 8];
                            end
                        end
                    end
                    if (offset == 14'd3) begin
                        if (sel_i[0]) begin
                            control_q <= dat_i[7:0];
                        end
                        pulse_q <= sel_i[3] & dat_i[31];
                    end
                    if (offset == 14'd5) begin
                        errcnt_q <= 16'd0;
                    end
                end
            end
        end
    end

    always_comb begin
        ack_o     = (state_q == RESP) && !resp_err_q;
        err_o     = (state_q == RESP) && resp_err_q;
        rty_o     = 1'b0;
        dat_o     = dat_q;
        control_o = control_q;
        pulse_o   = pulse_q;
    end

endmodule

// File: doc/wb_reg_responder.md
WB_REG_RESPONDER -- requirements
Module: wb_reg_responder

Interface
REQ-001 SHALL have parameter IDENT, default 32'h52445742, value returned by the ID register.
REQ-002 SHALL have parameter VERSION, default 32'h00010000, value returned by the VERSION register.
REQ-003 SHALL have parameter LATENCY, default 1, legal range 0-7: extra wait cycles before each response.
REQ-004 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports cyc_i in 1, stb_i in 1, we_i in 1: WISHBONE slave cycle, strobe and write-enable.
REQ-007 SHALL have ports adr_i in 16, dat_i in 32, sel_i in 4: byte address, write data, byte selects.
REQ-008 SHALL have ports ack_o out 1, err_o out 1, rty_o out 1, dat_o out 32: terminations and read data.
REQ-009 SHALL have ports control_o out 8 (CONTROL[7:0]) and pulse_o out 1 (one-cycle command strobe).

Function
REQ-010 SHALL decode word offset adr_i[15:2]: 0x0 ID (RO), 0x1 VERSION (RO), 0x2 SCRATCH (RW), 0x3 CONTROL (RW), 0x4 COUNTER (RO), 0x5 ERRCNT (RO, write-to-clear); adr_i[1:0] ignored.
REQ-011 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-012 SHALL leave IDLE on cyc_i&stb_i sampled high: to RESP if LATENCY=0, else to WAIT with wait counter loaded to LATENCY-1.
REQ-013 SHALL in WAIT decrement the counter each cycle, move to RESP when it reads 0, return to IDLE with no response if cyc_i or stb_i is sampled low (abort).
REQ-014 SHALL assert exactly one of ack_o/err_o for exactly one cycle while in RESP, then go to IDLE unconditionally.
REQ-015 SHALL thus give request sampled in cycle N a response in cycle N+1+LATENCY; held strobes are re-sampled only in IDLE, so back-to-back period is LATENCY+2 cycles.
REQ-016 SHALL assert err_o (not ack_o) for offsets 0x6 and above; no register changes; dat_o = 0.
REQ-017 SHALL commit writes on the clock edge that enters RESP, honouring sel_i per byte for SCRATCH and CONTROL.
REQ-018 SHALL ack and ignore writes to ID, VERSION, COUNTER.
REQ-019 SHALL clear ERRCNT on any acked write to offset 0x5 regardless of data/sel_i.
REQ-020 SHALL capture read data into dat_o on the edge entering RESP and hold dat_o until the next response.
REQ-021 SHALL drive control_o from CONTROL[7:0]; CONTROL[31] reads 0 always; CONTROL[30:8] read 0.
REQ-022 SHALL pulse pulse_o high for the single cycle after a write commit with sel_i[3]=1 and dat_i[31]=1.
REQ-023 SHALL increment COUNTER every cycle, 32-bit, wrapping 0xFFFFFFFF -> 0; read returns value at capture edge.
REQ-024 SHALL increment ERRCNT (bits [15:0], saturating at 0xFFFF, [31:16] read 0) once per err_o response.
REQ-025 SHALL tie rty_o to 0.
REQ-026 SHALL ignore cyc_i/stb_i changes while in RESP.

Reset
REQ-027 SHALL on rst_i low immediately force IDLE, ack_o=0, err_o=0, pulse_o=0, dat_o=0, control_o=0, SCRATCH=0, COUNTER=0, ERRCNT=0, wait counter=0.
REQ-028 SHALL, if reset asserts mid-transaction, drop the transaction with no commit and no response after release.
REQ-029 SHALL resume normal decode on the first rising edge after rst_i returns high.

Verification
REQ-030 LATENCY=1: read offset 0x0 sampled cycle N -> ack_o high cycle N+2 only, dat_o=0x52445742.
REQ-031 Write SCRATCH 0xDEADBEEF sel=4'b0101 after reset, read back -> 0x00AD00EF.
REQ-032 Write CONTROL 0x800000A5 sel=4'b1111 -> control_o=0xA5, pulse_o high exactly one cycle, CONTROL reads 0x000000A5.
REQ-033 Access offset 0x10 three times -> three err_o pulses, no ack_o, ERRCNT reads 3; write offset 0x5 -> ERRCNT reads 0.
REQ-034 LATENCY=3: drop cyc_i during WAIT -> no ack_o/err_o, SCRATCH unchanged; next request acked normally.
REQ-035 Assert rst_i low during WAIT of a SCRATCH write 0x12345678 -> ack_o stays 0, SCRATCH reads 0 after release.
